// File: rtl/sunflower_pkg.sv
// Shared definitions for the solar tracker sweep logic.
//   state_t        : sweep FSM encoding (IDLE / SWEEP / DONE)
//   ADC_W_DEFAULT  : default ADC sample width
//   clog2()        : index/counter width helper, never returns less than 1
package sunflower_pkg;

   localparam int ADC_W_DEFAULT = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Width needed to hold values 0..n-1. It returns at least 1, so a single-channel
   // build still gets a real 1-bit index port.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/sweep_peak_tracker_if.sv
// Sample stream and result bus of the sweep peak tracker.
//   master : sweep source / supervisor (drives start, abort, sample_valid, sample, position)
//   slave  : sweep_peak_tracker (drives busy, done, peak_value, peak_ch, peak_pos, sample_count)
interface sweep_peak_tracker_if #(
   parameter int ADC_W       = sunflower_pkg::ADC_W_DEFAULT,
   parameter int NUM_CH      = 4,
   parameter int POS_W       = 9,
   parameter int NUM_SAMPLES = 360
);
   localparam int CH_W  = sunflower_pkg::clog2(NUM_CH);
   localparam int CNT_W = sunflower_pkg::clog2(NUM_SAMPLES + 1);

   logic                    start;
   logic                    abort;
   logic                    sample_valid;
   logic [NUM_CH*ADC_W-1:0] sample;
   logic [POS_W-1:0]        position;
   logic                    busy;
   logic                    done;
   logic [ADC_W-1:0]        peak_value;
   logic [CH_W-1:0]         peak_ch;
   logic [POS_W-1:0]        peak_pos;
   logic [CNT_W-1:0]        sample_count;

   modport master (
      output start, abort, sample_valid, sample, position,
      input  busy, done, peak_value, peak_ch, peak_pos, sample_count
   );

   modport slave (
      input  start, abort, sample_valid, sample, position,
      output busy, done, peak_value, peak_ch, peak_pos, sample_count
   );

endinterface

// File: rtl/ch_argmax.sv
// Combinational NUM_CH-way unsigned maximum.
//   values    : channel c at [c*ADC_W +: ADC_W]
//   max_value : largest channel value
//   max_idx   : index of max_value; the lowest index wins a tie
module ch_argmax #(
   parameter int ADC_W  = 12,
   parameter int NUM_CH = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NUM_CH*ADC_W-1:0] values,
   output logic [ADC_W-1:0]        max_value,
   output logic [IDX_W-1:0]        max_idx
);

   // A strict greater-than means a later channel that only ties the current
   // maximum cannot replace it.
   always_comb begin
      max_value = values[0 +: ADC_W];
      max_idx   = '0;
      for (int c = 1; c < NUM_CH; c++) begin
         if (values[c*ADC_W +: ADC_W] > max_value) begin
            max_value = values[c*ADC_W +: ADC_W];
            max_idx   = IDX_W'(c);
         end
      end
   end

endmodule

// File: rtl/sweep_peak_tracker.sv
// Sequential peak finder for one solar tracker sweep of NUM_SAMPLES ADC samples.
// It records the largest reading, the channel it came from and the position at which it occurred.
//   clk, reset : rising-edge clock; reset is asynchronous and active-high
//   bus        : sweep_peak_tracker_if.slave
//                inputs : start, abort, sample_valid, sample, position
//                outputs: busy, done, peak_value, peak_ch, peak_pos, sample_count
// Optional build macro PEAK_TRACK_AVG_EN: each channel compares (cur + prev) >> 1
// instead of the raw sample. prev is the previous accepted sample of that channel.
//
// state | meaning
// IDLE  | waiting for start; results of the last sweep held
// SWEEP | accepting samples, tracking the running peak
// DONE  | one-cycle completion pulse, then back to IDLE
module sweep_peak_tracker
   import sunflower_pkg::*;
#(
   parameter int ADC_W       = ADC_W_DEFAULT,
   parameter int NUM_CH      = 4,
   parameter int POS_W       = 9,
   parameter int NUM_SAMPLES = 360
) (
   input  logic clk,
   input  logic reset,
   sweep_peak_tracker_if.slave bus
);

   localparam int CH_W  = clog2(NUM_CH);
   localparam int CNT_W = clog2(NUM_SAMPLES + 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [CNT_W-1:0]        cnt;
   logic [ADC_W-1:0]        peak_value;
   logic [CH_W-1:0]         peak_ch;
   logic [POS_W-1:0]        peak_pos;
   logic [NUM_CH*ADC_W-1:0] eff;
   logic [ADC_W-1:0]        cyc_max;
   logic [CH_W-1:0]         cyc_idx;
   logic                    sweep_start;
   logic                    accept;
   logic                    last_sample;

   // abort wins over a sample in the same cycle, so that sample is never counted.
   assign sweep_start = (state == IDLE) && bus.start;
   assign accept      = (state == SWEEP) && bus.sample_valid && !bus.abort;
   assign last_sample = accept && (cnt == CNT_W'(NUM_SAMPLES - 1));

`ifdef PEAK_TRACK_AVG_EN
   logic [NUM_CH*ADC_W-1:0] prev;
   logic [ADC_W:0]          avg_sum [NUM_CH];

   // The first sample of a sweep has no predecessor and is used unchanged.
   always_comb begin
      eff = bus.sample;
      for (int c = 0; c < NUM_CH; c++) begin
         avg_sum[c] = {1'b0, bus.sample[c*ADC_W +: ADC_W]} + {1'b0, prev[c*ADC_W +: ADC_W]};
         if (cnt != '0) eff[c*ADC_W +: ADC_W] = avg_sum[c][ADC_W:1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev <= '0;
      end else if (sweep_start) begin
         prev <= '0;
      end else if (accept) begin
         prev <= bus.sample;
      end
   end
`else
   assign eff = bus.sample;
`endif

   ch_argmax #(
      .ADC_W  (ADC_W),
      .NUM_CH (NUM_CH),
      .IDX_W  (CH_W)
   ) u_argmax (
      .values    (eff),
      .max_value (cyc_max),
      .max_idx   (cyc_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bus.busy  = 1'b0;
      bus.done  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = SWEEP;
         end
         SWEEP: begin
            bus.busy = 1'b1;
            if (bus.abort)       state_nxt = IDLE;
            else if (last_sample) state_nxt = DONE;
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The counter cannot run past NUM_SAMPLES: the sweep leaves SWEEP on the final accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         peak_value <= '0;
         peak_ch    <= '0;
         peak_pos   <= '0;
      end else if (sweep_start) begin
         cnt        <= '0;
         peak_value <= '0;
         peak_ch    <= '0;
         peak_pos   <= '0;
      end else if (accept) begin
         cnt <= cnt + 1'b1;
         if (cyc_max > peak_value) begin
            peak_value <= cyc_max;
            peak_ch    <= cyc_idx;
            peak_pos   <= bus.position;
         end
      end
   end

   assign bus.peak_value   = peak_value;
   assign bus.peak_ch      = peak_ch;
   assign bus.peak_pos     = peak_pos;
   assign bus.sample_count = cnt;

endmodule

// File: tb/tb_sweep_peak_tracker.sv
module tb_sweep_peak_tracker;

`ifdef PEAK_TRACK_AVG_EN
   localparam bit AVG = 1'b1;
`else
   localparam bit AVG = 1'b0;
`endif

   typedef struct packed {
      logic [7:0][3:0][11:0] smp;
      logic [8:0]            pos_base;
      logic [11:0]           exp_val;
      logic [1:0]            exp_ch;
      logic [8:0]            exp_pos;
   } sweep_vec_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_fail;

   sweep_vec_t vecs [5];

   sweep_peak_tracker_if #(.ADC_W(12), .NUM_CH(4), .POS_W(9), .NUM_SAMPLES(8)) bus ();

   sweep_peak_tracker #(
      .ADC_W       (12),
      .NUM_CH      (4),
      .POS_W       (9),
      .NUM_SAMPLES (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic valid, input logic [47:0] smp, input logic [8:0] pos);
      bus.sample_valid = valid;
      bus.sample       = smp;
      bus.position     = pos;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      int gaps;
      n_vec  = 0;
      n_fail = 0;

      for (int i = 0; i < 5; i++) vecs[i] = '0;
      // Ramp on channel 2.
      for (int k = 0; k < 8; k++) vecs[0].smp[k][2] = 12'(k * 10);
      vecs[0].exp_val = AVG ? 12'd65 : 12'd70;
      vecs[0].exp_ch  = 2'd2;
      vecs[0].exp_pos = 9'd7;
      // Ties: lowest channel and first occurrence win.
      for (int k = 0; k < 8; k++)
         for (int c = 0; c < 4; c++) vecs[1].smp[k][c] = 12'd100;
      vecs[1].smp[3][1] = 12'd500;
      vecs[1].smp[3][3] = 12'd500;
      vecs[1].smp[5][0] = 12'd500;
      vecs[1].exp_val = AVG ? 12'd300 : 12'd500;
      vecs[1].exp_ch  = 2'd1;
      vecs[1].exp_pos = 9'd3;
      // Single full-scale spike on channel 0.
      vecs[2].smp[1][0] = 12'd4095;
      vecs[2].exp_val = AVG ? 12'd2047 : 12'd4095;
      vecs[2].exp_ch  = 2'd0;
      vecs[2].exp_pos = 9'd1;
      // All-zero sweep at nonzero positions.
      vecs[3].pos_base = 9'd40;
      vecs[3].exp_val  = 12'd0;
      vecs[3].exp_ch   = 2'd0;
      vecs[3].exp_pos  = 9'd0;
      // Falling ramp on channel 3, with a low constant on channel 0.
      vecs[4].pos_base = 9'd200;
      for (int k = 0; k < 8; k++) begin
         vecs[4].smp[k][3] = 12'(800 - k * 100);
         vecs[4].smp[k][0] = 12'd50;
      end
      vecs[4].exp_val = 12'd800;
      vecs[4].exp_ch  = 2'd3;
      vecs[4].exp_pos = 9'd200;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      drive(1'b0, '0, '0);
      step();
      step();
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_done", 32'(bus.done), 0);
      check("reset_peak", 32'(bus.peak_value), 0);
      check("reset_count", 32'(bus.sample_count), 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 5; i++) begin
         do_start();
         check($sformatf("v%0d_busy", i), 32'(bus.busy), 1);
         check($sformatf("v%0d_cleared", i), 32'(bus.sample_count), 0);
         for (int k = 0; k < 8; k++) begin
            drive(1'b1, vecs[i].smp[k], vecs[i].pos_base + 9'(k));
            step();
            if (k == 6) check($sformatf("v%0d_early_done", i), 32'(bus.done), 0);
         end
         drive(1'b0, '0, '0);
         check($sformatf("v%0d_done", i), 32'(bus.done), 1);
         check($sformatf("v%0d_busy_end", i), 32'(bus.busy), 0);
         check($sformatf("v%0d_value", i), 32'(bus.peak_value), 32'(vecs[i].exp_val));
         check($sformatf("v%0d_ch", i), 32'(bus.peak_ch), 32'(vecs[i].exp_ch));
         check($sformatf("v%0d_pos", i), 32'(bus.peak_pos), 32'(vecs[i].exp_pos));
         check($sformatf("v%0d_count", i), 32'(bus.sample_count), 8);
         step();
         check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 0);
         check($sformatf("v%0d_hold", i), 32'(bus.peak_value), 32'(vecs[i].exp_val));
      end

      // Reset in the middle of a sweep.
      do_start();
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 48'(123 + k), 9'(k + 10));
         step();
      end
      drive(1'b0, '0, '0);
      check("midrst_pre_peak", 32'(bus.peak_value), AVG ? 124 : 125);
      #3 reset = 1'b1;
      #1;
      check("midrst_busy", 32'(bus.busy), 0);
      check("midrst_peak", 32'(bus.peak_value), 0);
      check("midrst_pos", 32'(bus.peak_pos), 0);
      check("midrst_count", 32'(bus.sample_count), 0);
      step();
      reset = 1'b0;
      step();

      // Random gaps, start pulses during SWEEP, and ignored data in the gaps.
      do_start();
      for (int k = 0; k < 8; k++) begin
         gaps = int'($urandom_range(0, 3));
         for (int g = 0; g < gaps; g++) begin
            bus.start = (g == 0);
            drive(1'b0, 48'd4000, 9'd99);
            step();
            bus.start = 1'b0;
         end
         drive(1'b1, 48'(10 * (k + 1)), 9'(k));
         step();
         if (k == 3) check("gap_count_mid", 32'(bus.sample_count), 4);
      end
      drive(1'b0, '0, '0);
      check("gap_done", 32'(bus.done), 1);
      check("gap_count", 32'(bus.sample_count), 8);
      check("gap_value", 32'(bus.peak_value), AVG ? 75 : 80);
      check("gap_pos", 32'(bus.peak_pos), 7);
      drive(1'b1, 48'd4000, 9'd99);
      step();
      step();
      step();
      drive(1'b0, '0, '0);
      check("gap_no_restart", 32'(bus.busy), 0);
      check("idle_ignore_value", 32'(bus.peak_value), AVG ? 75 : 80);
      check("idle_ignore_count", 32'(bus.sample_count), 8);

      // Abort after four samples, coincident with a fifth valid sample.
      do_start();
      drive(1'b1, {12'd0, 12'd0, 12'd300, 12'd0}, 9'd0); step();
      drive(1'b1, {12'd0, 12'd0, 12'd200, 12'd0}, 9'd1); step();
      drive(1'b1, {12'd0, 12'd900, 12'd0, 12'd0}, 9'd2); step();
      drive(1'b1, {12'd0, 12'd100, 12'd0, 12'd0}, 9'd3); step();
      bus.abort = 1'b1;
      drive(1'b1, 48'd1000, 9'd4);
      step();
      bus.abort = 1'b0;
      drive(1'b0, '0, '0);
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_done", 32'(bus.done), 0);
      check("abort_count", 32'(bus.sample_count), 4);
      check("abort_value", 32'(bus.peak_value), AVG ? 500 : 900);
      check("abort_pos", 32'(bus.peak_pos), AVG ? 3 : 2);
      step();
      check("abort_no_done", 32'(bus.done), 0);

      // Abort coinciding with the final sample wins.
      do_start();
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, 48'd5, 9'(k));
         step();
      end
      bus.abort = 1'b1;
      drive(1'b1, 48'd5, 9'd7);
      step();
      bus.abort = 1'b0;
      drive(1'b0, '0, '0);
      check("abort_last_done", 32'(bus.done), 0);
      check("abort_last_busy", 32'(bus.busy), 0);
      check("abort_last_count", 32'(bus.sample_count), 7);
      step();
      check("abort_last_no_done", 32'(bus.done), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
